sobel_stage: RTL and testbench

- Streaming 3x3 Sobel edge-magnitude stage between the grayscale FIFO (8-bit) and the output FIFO (8-bit) inside top_level.
- Consumes one grayscale pixel per transfer in raster order and produces exactly one output pixel per input pixel, WIDTH*HEIGHT per frame.
- Holds two image rows plus two pixels in an internal line buffer.
- Flushes the tail of each frame without further input, then rearms for the next frame.

---
 rtl/sobel_stage_if.sv | 15 +
 rtl/sobel_stage.sv | 153 +++++++++++++++
 tb/tb_sobel_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_stage_if.sv
// Pixel stream bundle between the grayscale FIFO, the Sobel stage and the output FIFO.
// master = FIFO/environment side, slave = Sobel stage side.
interface sobel_stage_if;
  logic [7:0] in_dout;
  logic       in_empty;
  logic       in_rd_en;
  logic [7:0] out_din;
  logic       out_full;
  logic       out_wr_en;

  modport master (output in_dout, in_empty, out_full,
                  input  in_rd_en, out_din, out_wr_en);
  modport slave  (input  in_dout, in_empty, out_full,
                  output in_rd_en, out_din, out_wr_en);
endinterface

// File: rtl/sobel_stage.sv
// Streaming 3x3 Sobel edge-magnitude stage, one output pixel per input pixel.
// Optional binarised output when SOBEL_THRESHOLD_EN is defined.
//
// state   | meaning
// S_FILL  | priming the line buffer with the first WIDTH+1 pixels, no output
// S_RUN   | one pixel consumed and one edge pixel written per transfer
// S_FLUSH | draining the last WIDTH+1 outputs with zero fill, no input
module sobel_stage #(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 720,
  parameter int THRESHOLD = 128
) (
  input  logic        clk,
  input  logic        rst,
  sobel_stage_if.slave pix
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CW    = $clog2(NPIX);
  localparam int COLW  = $clog2(WIDTH);
  localparam int ROWW  = $clog2(HEIGHT);
  localparam int SRLEN = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [COLW-1:0]   out_col_q, out_col_d;
  logic [ROWW-1:0]   out_row_q, out_row_d;
  logic [7:0]        sr_q [SRLEN];

  logic              rd_en, wr_en, shift;
  logic [7:0]        p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FILL;
      in_cnt_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
    end
  end

  // Line buffer holds image data only; its contents after reset never reach the output.
  always_ff @(posedge clk) begin
    if (shift) begin
      sr_q[0] <= p;
      for (int i = 1; i < SRLEN; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    shift     = 1'b0;
    p         = pix.in_dout;
    case (state_q)
      S_FILL: begin
        if (!pix.in_empty) begin
          rd_en    = 1'b1;
          shift    = 1'b1;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == CW'(WIDTH)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!pix.in_empty && !pix.out_full) begin
          rd_en = 1'b1;
          wr_en = 1'b1;
          shift = 1'b1;
          if (in_cnt_q == CW'(NPIX - 1)) begin
            in_cnt_d = '0;
            state_d  = S_FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        p = 8'h00;
        if (!pix.out_full) begin
          wr_en = 1'b1;
          shift = 1'b1;
          // The last frame output wraps the position counters back to (0,0).
          if (out_row_q == ROWW'(HEIGHT - 1) && out_col_q == COLW'(WIDTH - 1))
            state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
    if (rst) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
      shift = 1'b0;
    end
    if (wr_en) begin
      if (out_col_q == COLW'(WIDTH - 1)) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROWW'(HEIGHT - 1)) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  function automatic logic signed [11:0] ext(input logic [7:0] v);
    return $signed({4'b0000, v});
  endfunction

  logic [7:0]        tl, tc, tr, ml, mr, bl, bc, br;
  logic signed [11:0] gx, gy;
  logic [11:0]       ax, ay, mag;
  logic [7:0]        clamped, edge_val;
  logic              border;

  always_comb begin
    tl = sr_q[2*WIDTH+1];
    tc = sr_q[2*WIDTH];
    tr = sr_q[2*WIDTH-1];
    ml = sr_q[WIDTH+1];
    mr = sr_q[WIDTH-1];
    bl = sr_q[1];
    bc = sr_q[0];
    br = p;
    gx = (ext(tr) + (ext(mr) <<< 1) + ext(br)) - (ext(tl) + (ext(ml) <<< 1) + ext(bl));
    gy = (ext(bl) + (ext(bc) <<< 1) + ext(br)) - (ext(tl) + (ext(tc) <<< 1) + ext(tr));
    ax = gx[11] ? 12'(-gx) : 12'(gx);
    ay = gy[11] ? 12'(-gy) : 12'(gy);
    mag = ax + ay;
    clamped = (mag > 12'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESHOLD_EN
    edge_val = (int'(clamped) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    edge_val = clamped;
`endif
    border = (out_row_q == '0) || (out_row_q == ROWW'(HEIGHT - 1)) ||
             (out_col_q == '0) || (out_col_q == COLW'(WIDTH - 1));
  end

  assign pix.in_rd_en  = rd_en;
  assign pix.out_wr_en = wr_en;
  assign pix.out_din   = (rst || state_q == S_FILL || border) ? 8'h00 : edge_val;

endmodule

// File: tb/tb_sobel_stage.sv
// Randomised self-checking bench for sobel_stage against a per-frame Sobel model.
module tb_sobel_stage;
  localparam int W = 8, H = 6, N = W * H, THR = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_stage_if bus();
  sobel_stage #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .pix(bus)
  );

  int n_cmp = 0, n_err = 0;
  logic [7:0] frame [H][W];
  logic [7:0] in_q [$];
  logic [7:0] exp_q [$];
  int consumed, written, gap_pct, full_pct, hold_left;
  bit chk_out, hold_pending;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Queue the frame for input and its expected Sobel image for output.
  function automatic void push_frame();
    int gx, gy, m;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        in_q.push_back(frame[r][c]);
        if (r == 0 || r == H-1 || c == 0 || c == W-1) exp_q.push_back(8'h00);
        else begin
          gx = (frame[r-1][c+1] + 2*frame[r][c+1] + frame[r+1][c+1])
             - (frame[r-1][c-1] + 2*frame[r][c-1] + frame[r+1][c-1]);
          gy = (frame[r+1][c-1] + 2*frame[r+1][c] + frame[r+1][c+1])
             - (frame[r-1][c-1] + 2*frame[r-1][c] + frame[r-1][c+1]);
          m = absi(gx) + absi(gy);
          if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
          m = (m >= THR) ? 255 : 0;
`endif
          exp_q.push_back(8'(m));
        end
      end
  endfunction

  function automatic void step_frame(input int lo, input int hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 8'((c < 4) ? lo : hi);
  endfunction

  function automatic void rand_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = 8'($urandom_range(0, 255));
  endfunction

  task automatic drive();
    bus.in_empty = (in_q.size() == 0) || ($urandom_range(0, 99) < gap_pct);
    bus.in_dout  = (in_q.size() != 0) ? in_q[0] : 8'($urandom);
    if (hold_pending && consumed > 0 && consumed % N == 0 && written < consumed) begin
      hold_left    = 20;
      hold_pending = 1'b0;
    end
    if (hold_left > 0) begin
      bus.out_full = 1'b1;
      hold_left--;
    end else begin
      bus.out_full = ($urandom_range(0, 99) < full_pct);
    end
  endtask

  task automatic tick();
    bit rd, wr;
    @(negedge clk);
    rd = bus.in_rd_en;
    wr = bus.out_wr_en;
    if (consumed > 0 && consumed % N == 0 && written < consumed) check("rd_in_flush", rd, 0);
    if (rd && bus.in_empty) check("rd_while_empty", 1, 0);
    if (wr) begin
      check("no_wr_full", bus.out_full, 0);
      if (chk_out) begin
        if (written % N == 0) check("first_wr_latency", consumed + int'(rd) - written, W + 2);
        if (exp_q.size() == 0) check("unexpected_wr", 1, 0);
        else check("pix", bus.out_din, exp_q.pop_front());
      end
    end
    if (rd) consumed++;
    if (wr) written++;
    @(posedge clk);
    #1;
    if (rd && in_q.size() != 0) void'(in_q.pop_front());
    drive();
  endtask

  task automatic run_until(input int target, input int budget);
    int cyc = 0;
    drive();
    while (written < target && cyc < budget) begin
      tick();
      cyc++;
    end
    check("writes_done", written, target);
    repeat (30) tick();
    check("write_count", written, target);
    check("exp_drained", exp_q.size(), 0);
  endtask

  task automatic new_run(input int gp, input int fp);
    consumed = 0;
    written  = 0;
    gap_pct  = gp;
    full_pct = fp;
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_rd"}, bus.in_rd_en, 0);
    check({tag, "_wr"}, bus.out_wr_en, 0);
    check({tag, "_din"}, bus.out_din, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_empty = 1'b0;
    bus.in_dout  = 8'h55;
    bus.out_full = 1'b0;
    chk_out = 1'b1;
    hold_pending = 1'b0;
    hold_left = 0;
    new_run(0, 0);
    #2 check_rst_outputs("rst_init");
    repeat (3) @(posedge clk);
    #1 check_rst_outputs("rst_init2");
    rst = 1'b0;

    step_frame(77, 77);
    push_frame();
    run_until(N, 400);

    new_run(0, 0);
    step_frame(0, 20);
    push_frame();
    run_until(N, 400);

    new_run(0, 0);
    step_frame(0, 200);
    push_frame();
    run_until(N, 400);

    new_run(30, 40);
    rand_frame();
    push_frame();
    hold_pending = 1'b1;
    run_until(N, 2000);
    check("flush_hold_used", hold_pending, 0);

    new_run(0, 0);
    rand_frame();
    push_frame();
    rand_frame();
    push_frame();
    run_until(2 * N, 800);

    new_run(0, 0);
    chk_out = 1'b0;
    rand_frame();
    for (int i = 0; i < 20; i++) in_q.push_back(frame[i / W][i % W]);
    drive();
    for (int c = 0; c < 200 && consumed < 20; c++) tick();
    check("partial_consumed", consumed, 20);
    rst = 1'b1;
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    #2 check_rst_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1 check_rst_outputs("rst_mid2");
    rst = 1'b0;
    in_q.delete();
    exp_q.delete();
    chk_out = 1'b1;
    new_run(20, 20);
    rand_frame();
    push_frame();
    run_until(N, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
